// File: rtl/exe_mem_pkg.sv
// exe_mem_pkg: shared types and default widths for the EXE->MEM pipeline register
package exe_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [DATA_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] alu_result;
        logic [DATA_W_DEF-1:0] st_val;
        logic [DEST_W_DEF-1:0] dest;
    } exe_mem_payload_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;

endpackage

// File: rtl/exe_mem_perf_cnt.sv
// exe_mem_perf_cnt: saturating stall/bubble counter pair, cleared only by rst
module exe_mem_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // count each event cycle, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: EXE->MEM register with 2-entry skid buffer and flush; PIPE_REG_STATS_EN adds stall/bubble counters
module exe_mem_skid_reg
    import exe_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF
`ifdef PIPE_REG_STATS_EN
    ,parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic              in_mem_w_en,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_st_val,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_st_val,
    output logic [DEST_W-1:0] out_dest
`ifdef PIPE_REG_STATS_EN
    ,output logic [CNT_W-1:0] stall_cnt
    ,output logic [CNT_W-1:0] bubble_cnt
`endif
);

    // same field order as exe_mem_payload_t, sized by this instance's parameters
    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] st_val;
        logic [DEST_W-1:0] dest;
    } payload_t;

    skid_state_e state_q, state_d;
    payload_t    in_p, main_q, skid_q;
    logic        in_fire, main_ld, skid_ld;

    assign in_p    = {in_wb_en, in_mem_r_en, in_mem_w_en, in_pc, in_alu_result, in_st_val, in_dest};
    assign in_fire = in_valid & in_ready;
    assign main_ld = !flush && (state_q == TWO ? out_ready : in_fire && (state_q == EMPTY || out_ready));
    assign skid_ld = !flush && state_q == ONE && in_fire && !out_ready;

    // occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else state_q <= state_d;
    end

    // occupancy transitions; flush empties both slots regardless of traffic
    always_comb begin
        state_d = state_q;
        if (flush) state_d = EMPTY;
        else
            case (state_q)
                EMPTY:   state_d = in_fire ? ONE : EMPTY;
                ONE:     state_d = (in_fire && !out_ready) ? TWO : (!in_fire && out_ready) ? EMPTY : ONE;
                TWO:     state_d = out_ready ? ONE : TWO;
                default: state_d = EMPTY;
            endcase
    end

    // ready comes straight from the state flop; enables are masked when the main slot is empty
    always_comb begin
        in_ready       = state_q != TWO;
        out_valid      = state_q != EMPTY;
        out_wb_en      = out_valid & main_q.wb_en;
        out_mem_r_en   = out_valid & main_q.mem_r_en;
        out_mem_w_en   = out_valid & main_q.mem_w_en;
        out_pc         = main_q.pc;
        out_alu_result = main_q.alu_result;
        out_st_val     = main_q.st_val;
        out_dest       = main_q.dest;
    end

    // payload slots; contents survive pop and flush, only the state says they are dead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_ld) main_q <= (state_q == TWO) ? skid_q : in_p;
            if (skid_ld) skid_q <= in_p;
        end
    end

`ifdef PIPE_REG_STATS_EN
    exe_mem_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk        (clk),
        .rst        (rst),
        .stall      (out_valid & !out_ready),
        .bubble     (!out_valid),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );
`endif

endmodule
